// File: rtl/snake_pkg.sv
// Shared constants and encodings for the snake game blocks.
package snake_pkg;

    localparam int unsigned GRID_W  = 40;
    localparam int unsigned GRID_H  = 30;
    localparam int unsigned XW      = 6;
    localparam int unsigned YW      = 6;
    localparam int unsigned SPAWN_X = 10;
    localparam int unsigned SPAWN_Y = 10;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_DEAD
    } state_t;

    function automatic dir_t dir_reverse(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:   r = DIR_DOWN;
            DIR_DOWN: r = DIR_UP;
            DIR_LEFT: r = DIR_RIGHT;
            default:  r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_collision_check.sv
// Combinational wall / self-collision test for a proposed next head position.
module snake_collision_check #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned GRID_W  = snake_pkg::GRID_W,
    parameter int unsigned GRID_H  = snake_pkg::GRID_H
) (
    input  logic [snake_pkg::XW-1:0]              next_x_i,
    input  logic [snake_pkg::YW-1:0]              next_y_i,
    input  logic [MAX_LEN-1:0][snake_pkg::XW-1:0] seg_x_i,
    input  logic [MAX_LEN-1:0][snake_pkg::YW-1:0] seg_y_i,
    input  logic [4:0]                            length_i,
    input  logic                                  grow_i,
    output logic                                  wall_hit_o,
    output logic                                  body_hit_o
);
    import snake_pkg::*;

    int unsigned live;

    always_comb begin
        wall_hit_o = (next_x_i == '0) || (next_x_i == XW'(GRID_W - 1)) ||
                     (next_y_i == '0) || (next_y_i == YW'(GRID_H - 1));
        // Without growth the tail moves away this step, so its cell is free.
        live       = grow_i ? 32'(length_i) : 32'(length_i) - 32'd1;
        body_hit_o = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < live && seg_x_i[i] == next_x_i && seg_y_i[i] == next_y_i) begin
                body_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement engine: segment list, stepped head motion, growth and collision stop.
module snake_body_engine #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned INIT_LEN    = 3,
    parameter int unsigned STEP_CYCLES = 12_500_000,
    parameter int unsigned GRID_W      = snake_pkg::GRID_W,
    parameter int unsigned GRID_H      = snake_pkg::GRID_H
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic [3:0] dir_key,
    input  logic       add_cube,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] length,
    input  logic [5:0] pix_x,
    input  logic [4:0] pix_y,
    output logic       pix_is_body,
    output logic       game_over
);
    import snake_pkg::*;

    localparam int unsigned   CW       = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

    state_t                     state_q, state_d;
    dir_t                       dir_q, dir_d;
    dir_t                       last_q, last_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       add_prev_q;
    logic                       grow_q, grow_d;
    logic [4:0]                 len_q, len_d;
    logic [MAX_LEN-1:0][XW-1:0] seg_x_q, seg_x_d;
    logic [MAX_LEN-1:0][YW-1:0] seg_y_q, seg_y_d;
    logic                       pix_q;

    logic                       key_onehot;
    dir_t                       key_dir;
    logic                       key_ok;
    logic                       add_rise;
    logic [XW-1:0]              nx;
    logic [YW-1:0]              ny;
    logic                       fire;
    logic                       grow_now;
    logic                       wall_hit;
    logic                       body_hit;
    logic                       pix_hit;

    always_comb begin
        key_onehot = 1'b1;
        key_dir    = DIR_RIGHT;
        case (dir_key)
            4'b1000: key_dir = DIR_UP;
            4'b0100: key_dir = DIR_DOWN;
            4'b0010: key_dir = DIR_LEFT;
            4'b0001: key_dir = DIR_RIGHT;
            default: key_onehot = 1'b0;
        endcase
        // Reversal is judged against the executed move, not the pending one.
        key_ok = key_onehot && (key_dir != dir_reverse(last_q));
    end

    assign add_rise = add_cube && !add_prev_q;
    assign fire     = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign grow_now = grow_q && (len_q < 5'(MAX_LEN));

    always_comb begin
        nx = seg_x_q[0];
        ny = seg_y_q[0];
        case (dir_q)
            DIR_UP:   ny = seg_y_q[0] - 6'd1;
            DIR_DOWN: ny = seg_y_q[0] + 6'd1;
            DIR_LEFT: nx = seg_x_q[0] - 6'd1;
            default:  nx = seg_x_q[0] + 6'd1;
        endcase
    end

    snake_collision_check #(
        .MAX_LEN (MAX_LEN),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H)
    ) u_collision (
        .next_x_i   (nx),
        .next_y_i   (ny),
        .seg_x_i    (seg_x_q),
        .seg_y_i    (seg_y_q),
        .length_i   (len_q),
        .grow_i     (grow_now),
        .wall_hit_o (wall_hit),
        .body_hit_o (body_hit)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grow_d  = grow_q;
        len_d   = len_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d  = '0;
                grow_d = grow_q | add_rise;
                if (key_ok) begin
                    state_d = ST_RUN;
                    dir_d   = key_dir;
                end
            end
            ST_RUN: begin
                grow_d = grow_q | add_rise;
                if (key_ok) begin
                    dir_d = key_dir;
                end
                if (fire) begin
                    cnt_d = '0;
                    if (wall_hit || body_hit) begin
                        state_d = ST_DEAD;
                    end else begin
                        seg_x_d = {seg_x_q[MAX_LEN-2:0], nx};
                        seg_y_d = {seg_y_q[MAX_LEN-2:0], ny};
                        last_d  = dir_q;
                        // An edge arriving on the step edge survives for the next step.
                        grow_d  = add_rise;
                        if (grow_now) begin
                            len_d = len_q + 5'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pix_hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len_q) && seg_x_q[i] == pix_x && seg_y_q[i] == {1'b0, pix_y}) begin
                pix_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_WAIT;
            dir_q      <= DIR_RIGHT;
            last_q     <= DIR_RIGHT;
            cnt_q      <= '0;
            add_prev_q <= 1'b0;
            grow_q     <= 1'b0;
            len_q      <= 5'(INIT_LEN);
            pix_q      <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? XW'(SPAWN_X - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? YW'(SPAWN_Y) : '0;
            end
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            add_prev_q <= add_cube;
            grow_q     <= grow_d;
            len_q      <= len_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            pix_q      <= pix_hit;
        end
    end

    assign head_x      = seg_x_q[0];
    assign head_y      = seg_y_q[0];
    assign length      = len_q;
    assign game_over   = (state_q == ST_DEAD);
    assign pix_is_body = pix_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed self-checking bench for snake_body_engine (4-clock steps, 8 segments).
module tb_snake_body_engine;

    localparam logic [3:0] K_UP    = 4'b1000;
    localparam logic [3:0] K_DOWN  = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dir_key = '0;
    logic       add_cube = 1'b0;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [4:0] length;
    logic [5:0] pix_x = '0;
    logic [4:0] pix_y = '0;
    logic       pix_is_body;
    logic       game_over;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    snake_body_engine #(
        .MAX_LEN     (8),
        .INIT_LEN    (3),
        .STEP_CYCLES (4),
        .GRID_W      (40),
        .GRID_H      (30)
    ) dut (
        .CLK_50M     (clk),
        .RSTn        (rst_n),
        .dir_key     (dir_key),
        .add_cube    (add_cube),
        .head_x      (head_x),
        .head_y      (head_y),
        .length      (length),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_is_body (pix_is_body),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        dir_key  = '0;
        add_cube = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Leaves the bench on the falling edge right after the FSM entered RUN.
    task automatic start(input logic [3:0] key);
        dir_key = key;
        tick(1);
        dir_key = '0;
    endtask

    // From just after one step edge to just after the next, key held one cycle.
    task automatic step_with(input logic [3:0] key);
        dir_key = key;
        tick(1);
        dir_key = '0;
        tick(3);
    endtask

    task automatic query(input string tag, input logic [5:0] qx, input logic [4:0] qy,
                         input logic exp);
        pix_x = qx;
        pix_y = qy;
        tick(1);
        chk(tag, 32'(pix_is_body), 32'(exp));
    endtask

    task automatic chk_head(input string tag, input int unsigned ex, input int unsigned ey);
        chk({tag, "_x"}, 32'(head_x), ex);
        chk({tag, "_y"}, 32'(head_y), ey);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        do_reset();
        chk_head("rst_head", 10, 10);
        chk("rst_len", 32'(length), 3);
        chk("rst_go", 32'(game_over), 0);
        chk("rst_pix", 32'(pix_is_body), 0);
        tick(100);
        chk_head("idle_head", 10, 10);
        chk("idle_len", 32'(length), 3);
        chk("idle_go", 32'(game_over), 0);
        query("pix_9_10", 6'd9, 5'd10, 1'b1);
        query("pix_8_10", 6'd8, 5'd10, 1'b1);
        query("pix_7_10", 6'd7, 5'd10, 1'b0);
        query("pix_0_0_dead_slot", 6'd0, 5'd0, 1'b0);

        // First move timing and key filter
        do_reset();
        start(K_RIGHT);
        tick(3);
        chk_head("pre_step", 10, 10);
        tick(1);
        chk_head("step1", 11, 10);
        step_with('0);
        chk_head("step2", 12, 10);
        step_with(K_LEFT);
        chk_head("reverse_ignored", 13, 10);
        dir_key = K_UP;
        tick(1);
        dir_key = K_DOWN;
        tick(1);
        dir_key = '0;
        tick(2);
        chk_head("pending_overwrite", 13, 11);
        step_with(4'b1001);
        chk_head("multi_key_ignored", 13, 12);
        chk("run_len", 32'(length), 3);

        // Held add_cube grows exactly once
        do_reset();
        start(K_RIGHT);
        add_cube = 1'b1;
        tick(4);
        chk("hold_grow_len", 32'(length), 4);
        chk_head("hold_grow_head", 11, 10);
        tick(46);
        add_cube = 1'b0;
        tick(8);
        chk("hold_no_regrow", 32'(length), 4);

        // Edge coinciding with a step applies one step later; cap at MAX_LEN
        do_reset();
        start(K_RIGHT);
        tick(3);
        add_cube = 1'b1;
        tick(1);
        chk("edge_on_step_len", 32'(length), 3);
        add_cube = 1'b0;
        tick(4);
        chk("edge_next_step_len", 32'(length), 4);
        for (int k = 0; k < 5; k++) begin
            add_cube = 1'b1;
            tick(1);
            add_cube = 1'b0;
            tick(3);
        end
        chk("cap_len", 32'(length), 8);
        chk_head("cap_head", 17, 10);
        step_with('0);
        chk("cap_dropped_len", 32'(length), 8);
        chk_head("cap_dropped_head", 18, 10);
        chk("cap_go", 32'(game_over), 0);
        query("pix_tail_11", 6'd11, 5'd10, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_len", 32'(length), 3);
        chk_head("async_rst_head", 10, 10);

        // Wall collision
        do_reset();
        start(K_UP);
        tick(4);
        chk_head("up1", 10, 9);
        tick(32);
        chk_head("up9", 10, 1);
        chk("up9_go", 32'(game_over), 0);
        tick(3);
        chk("pre_wall_go", 32'(game_over), 0);
        tick(1);
        chk("wall_go", 32'(game_over), 1);
        chk_head("wall_head", 10, 1);
        step_with(K_RIGHT);
        step_with(K_DOWN);
        chk("dead_go", 32'(game_over), 1);
        chk_head("dead_head", 10, 1);
        chk("dead_len", 32'(length), 3);
        do_reset();
        chk("go_cleared", 32'(game_over), 0);

        // Loop at length 4: head enters the vacating tail cell
        start(K_RIGHT);
        add_cube = 1'b1;
        tick(1);
        add_cube = 1'b0;
        tick(3);
        chk("l4_len", 32'(length), 4);
        step_with('0);
        step_with(K_DOWN);
        step_with(K_LEFT);
        chk_head("l4_pre", 11, 11);
        step_with(K_UP);
        chk_head("l4_tail_ok", 11, 10);
        chk("l4_go", 32'(game_over), 0);
        query("l4_pix_11_11", 6'd11, 5'd11, 1'b1);

        // Same loop at length 5 bites the body
        do_reset();
        start(K_RIGHT);
        add_cube = 1'b1;
        tick(1);
        add_cube = 1'b0;
        tick(3);
        step_with('0);
        add_cube = 1'b0;
        chk("l5_len_pre", 32'(length), 4);
        add_cube = 1'b1;
        tick(1);
        add_cube = 1'b0;
        tick(3);
        chk("l5_len", 32'(length), 5);
        chk_head("l5_start", 13, 10);
        do_reset();
        start(K_RIGHT);
        add_cube = 1'b1;
        tick(1);
        add_cube = 1'b0;
        tick(3);
        add_cube = 1'b1;
        tick(1);
        add_cube = 1'b0;
        tick(3);
        chk("l5b_len", 32'(length), 5);
        chk_head("l5b_head", 12, 10);
        step_with(K_DOWN);
        step_with(K_LEFT);
        chk_head("l5_pre", 11, 11);
        step_with(K_UP);
        chk("l5_self_go", 32'(game_over), 1);
        chk_head("l5_self_head", 11, 11);
        chk("l5_self_len", 32'(length), 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
